// File: rtl/mcu_block_sched.sv
// Block scheduler for the DCT transpose memory: grants whole 64-sample blocks to Y/Cb/Cr in MCU
// order and tags the memory output stream. Define MCU_420_EN for 4:2:0 MCUs (default 4:4:4).
module mcu_block_sched #(
    parameter int unsigned MCU_Y_BLOCKS = 4,
    parameter int unsigned TAG_DEPTH    = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic [2:0]        req,
    input  logic signed [9:0] in_data_y,
    input  logic signed [9:0] in_data_cb,
    input  logic signed [9:0] in_data_cr,
    output logic [2:0]        grant,
    output logic signed [9:0] mem_data,
    output logic              mem_en,
    input  logic              mem_en_out,
    output logic [1:0]        out_comp,
    output logic              out_block_start,
    output logic              out_block_last,
    output logic              mcu_done,
    output logic              err
);

`ifdef MCU_420_EN
    localparam int unsigned NumY = MCU_Y_BLOCKS;
    localparam int unsigned PosW = $clog2(MCU_Y_BLOCKS + 2);
`else
    // A 4:4:4 MCU always carries a single Y block, whatever MCU_Y_BLOCKS says.
    localparam int unsigned NumY = (MCU_Y_BLOCKS != 0) ? 1 : 1;
    localparam int unsigned PosW = 2;
`endif
    localparam int unsigned LastPos = NumY + 1;
    localparam int unsigned PtrW    = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    typedef enum logic {StIdle, StGrant} state_e;

    state_e            state_q;
    logic [5:0]        cnt_q;
    logic [5:0]        out_cnt_q;
    logic [PosW-1:0]   pos_q;
    logic              fs_pend_q;
    logic [2:0]        grant_q;
    logic              mcu_done_q;
    logic              err_q;
    logic [1:0]        tag_mem [TAG_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW:0]     count_q;

    logic              fifo_empty;
    logic              fifo_pop;
    logic              push_blocked;
    logic              blk_end;
    logic              restart;
    logic [PosW-1:0]   pos_adv;
    logic [PosW-1:0]   pos_sel;
    logic [1:0]        comp_sel;
    logic              start;

    function automatic logic [1:0] comp_of(input logic [PosW-1:0] p);
        if (p < PosW'(NumY)) begin
            return 2'd0;
        end else if (p == PosW'(NumY)) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

    assign fifo_empty   = (count_q == '0);
    assign fifo_pop     = out_block_last && !fifo_empty;
    // A pop in the same cycle frees the slot the new tag needs.
    assign push_blocked = (count_q == (PtrW + 1)'(TAG_DEPTH)) && !fifo_pop;

    assign blk_end = (state_q == StGrant) && (cnt_q == 6'd63);
    assign restart = frame_start || fs_pend_q;
    assign pos_adv = (pos_q == PosW'(LastPos)) ? '0 : pos_q + 1'b1;

    always_comb begin
        pos_sel = pos_q;
        if (state_q == StIdle) begin
            pos_sel = restart ? '0 : pos_q;
        end else if (blk_end) begin
            pos_sel = restart ? '0 : pos_adv;
        end
    end

    assign comp_sel = comp_of(pos_sel);
    assign start    = ((state_q == StIdle) || blk_end) && req[comp_sel] && !push_blocked;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pos_q      <= '0;
            fs_pend_q  <= 1'b0;
            grant_q    <= '0;
            mcu_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mcu_done_q <= 1'b0;
            if (mem_en_out && fifo_empty) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    pos_q <= pos_sel;
                    if (start) begin
                        state_q <= StGrant;
                        grant_q <= 3'b001 << comp_sel;
                        cnt_q   <= '0;
                    end
                end
                StGrant: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        pos_q      <= pos_sel;
                        fs_pend_q  <= 1'b0;
                        mcu_done_q <= (pos_q == PosW'(LastPos));
                        if (start) begin
                            grant_q <= 3'b001 << comp_sel;
                        end else begin
                            grant_q <= '0;
                            state_q <= StIdle;
                        end
                    end else if (frame_start) begin
                        fs_pend_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_cnt_q <= '0;
        end else begin
            if (start) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (PtrW + 1)'(start) - (PtrW + 1)'(fifo_pop);
            // Stray output-valid with no tag is flagged, not counted.
            if (mem_en_out && !fifo_empty) begin
                out_cnt_q <= out_cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (start) begin
            tag_mem[wr_ptr_q] <= comp_sel;
        end
    end

    always_comb begin
        mem_data = '0;
        unique case (grant_q)
            3'b001:  mem_data = in_data_y;
            3'b010:  mem_data = in_data_cb;
            3'b100:  mem_data = in_data_cr;
            default: mem_data = '0;
        endcase
    end

    assign grant           = grant_q;
    assign mem_en          = |grant_q;
    assign mcu_done        = mcu_done_q;
    assign err             = err_q;
    assign out_comp        = fifo_empty ? 2'd0 : tag_mem[rd_ptr_q];
    assign out_block_start = mem_en_out && (out_cnt_q == 6'd0);
    assign out_block_last  = mem_en_out && (out_cnt_q == 6'd63);

endmodule

// File: tb/tb_mcu_block_sched.sv
// Directed bench for mcu_block_sched; a 64-cycle delay line stands in for the ping-pong memory.
module tb_mcu_block_sched;

`ifdef MCU_420_EN
    localparam int NY = 4;
`else
    localparam int NY = 1;
`endif
    localparam int NBLK = NY + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_start;
    logic [2:0]        req;
    logic signed [9:0] in_data_y;
    logic signed [9:0] in_data_cb;
    logic signed [9:0] in_data_cr;
    logic [2:0]        grant;
    logic signed [9:0] mem_data;
    logic              mem_en;
    logic              mem_en_out;
    logic [1:0]        out_comp;
    logic              out_block_start;
    logic              out_block_last;
    logic              mcu_done;
    logic              err;

    logic [63:0] dly = '0;
    logic        use_model;
    logic        force_en;
    int          checks = 0;
    int          errors = 0;
    int          run;
    int          done_cnt;
    int          done_at;

    always #5 clk = ~clk;

    always @(posedge clk) dly <= {dly[62:0], mem_en};
    assign mem_en_out = use_model ? dly[63] : force_en;

    mcu_block_sched dut (
        .clock          (clk),
        .reset_n        (rst_n),
        .frame_start    (frame_start),
        .req            (req),
        .in_data_y      (in_data_y),
        .in_data_cb     (in_data_cb),
        .in_data_cr     (in_data_cr),
        .grant          (grant),
        .mem_data       (mem_data),
        .mem_en         (mem_en),
        .mem_en_out     (mem_en_out),
        .out_comp       (out_comp),
        .out_block_start(out_block_start),
        .out_block_last (out_block_last),
        .mcu_done       (mcu_done),
        .err            (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_comp(input int b);
        if (b < NY) return 0;
        if (b == NY) return 1;
        return 2;
    endfunction

    function automatic int exp_data(input int c);
        if (c == 0) return 11;
        if (c == 1) return -22;
        return 33;
    endfunction

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        req = 3'b000;
        use_model = 1'b0;
        force_en = 1'b0;
        in_data_y = 10'sd11;
        in_data_cb = -10'sd22;
        in_data_cr = 10'sd33;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_data", 32'(mem_data), 0);
        check("rst_mcu_done", 32'(mcu_done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_start", 32'(out_block_start), 0);
        check("rst_last", 32'(out_block_last), 0);
        check("rst_comp", 32'(out_comp), 0);
        @(negedge clk);
        rst_n = 1'b1;
        use_model = 1'b1;
        tick();

        // Only Cb requesting at Pos 0 must not be granted.
        req = 3'b010;
        repeat (5) tick();
        check("cb_ignored", 32'(grant), 0);

        // Single Y block: latency, length and output tagging.
        req = 3'b001;
        for (int i = 1; i <= 135; i++) begin
            tick();
            if (i == 1) begin
                check("y_grant_first", 32'(grant), 1);
                check("y_data", 32'(mem_data), 32'(11));
            end
            if (i == 30) req = 3'b000;
            if (i == 64) check("y_grant_64", 32'(grant), 1);
            if (i == 65) begin
                check("y_grant_65", 32'(grant), 0);
                check("y_out_start", 32'(out_block_start), 1);
                check("y_out_comp", 32'(out_comp), 0);
            end
            if (i == 127) check("y_out_last_early", 32'(out_block_last), 0);
            if (i == 128) check("y_out_last", 32'(out_block_last), 1);
            if (i == 129) begin
                use_model = 1'b0;
                force_en = 1'b1;
            end
            if (i == 130) begin
                check("err_set", 32'(err), 1);
                force_en = 1'b0;
            end
            if (i == 135) begin
                check("err_sticky", 32'(err), 1);
                use_model = 1'b1;
            end
        end

        // Full MCU with all requests held.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        req = 3'b111;
        run = 0;
        done_cnt = 0;
        done_at = 0;
        for (int i = 1; i <= NBLK * 64 + 70; i++) begin
            tick();
            if (mem_en && i <= NBLK * 64) run++;
            if (mcu_done) begin
                done_cnt++;
                done_at = i;
            end
            for (int b = 0; b < NBLK; b++) begin
                if (i == 1 + 64 * b) begin
                    check("mcu_grant_order", 32'(grant), 32'(1 << exp_comp(b)));
                    check("mcu_data", 32'(mem_data), 32'(exp_data(exp_comp(b))));
                end
                if (i == 65 + 64 * b) begin
                    check("mcu_out_start", 32'(out_block_start), 1);
                    check("mcu_out_comp", 32'(out_comp), 32'(exp_comp(b)));
                end
            end
            if (i == NBLK * 64 - 10) req = 3'b000;
            if (i == NBLK * 64 + 1) check("mcu_end_mem_en", 32'(mem_en), 0);
        end
        check("mcu_run_len", 32'(run), 32'(NBLK * 64));
        check("mcu_done_count", 32'(done_cnt), 1);
        check("mcu_done_cycle", 32'(done_at), 32'(NBLK * 64 + 1));

        // Frame_Start during the Cb block restarts at Y after Cb finishes.
        req = 3'b111;
        for (int i = 1; i <= 64 * (NY + 2) + 5; i++) begin
            tick();
            if (i == 64 * NY + 31) frame_start = 1'b1;
            if (i == 64 * NY + 32) frame_start = 1'b0;
            if (i == 64 * NY + 40) check("fs_cb_continues", 32'(grant), 2);
            if (i == 64 * (NY + 1) + 1) check("fs_next_is_y", 32'(grant), 1);
            if (i == 64 * (NY + 1) + 10) req = 3'b000;
            if (i == 64 * (NY + 2) + 1) check("fs_then_idle", 32'(grant), 0);
        end
        repeat (140) tick();

        // Downstream stalled: four tags fill the FIFO, fifth grant waits for a pop.
        use_model = 1'b0;
        force_en = 1'b0;
        req = 3'b111;
        for (int i = 1; i <= 4 * 64 + 20; i++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (i == 1 + 64 * k) check("stall_grant_k", 32'(mem_en), 1);
            end
            if (i == 4 * 64 + 1 || i == 4 * 64 + 20) check("stall_no_fifth", 32'(grant), 0);
        end
        force_en = 1'b1;
        for (int j = 1; j <= 74; j++) begin
            tick();
            if (j == 1) check("stall_head_comp", 32'(out_comp), (NY > 1) ? 0 : 1);
            if (j == 63) begin
                check("stall_pop_last", 32'(out_block_last), 1);
                check("stall_still_waiting", 32'(grant), 0);
            end
            if (j == 64) begin
                check("stall_fifth_grant", 32'(mem_en), 1);
                force_en = 1'b0;
            end
        end

        // Reset in the middle of a block (Cnt=10).
        rst_n = 1'b0;
        req = 3'b000;
        #1;
        check("mid_rst_grant", 32'(grant), 0);
        check("mid_rst_mem_en", 32'(mem_en), 0);
        check("mid_rst_mem_data", 32'(mem_data), 0);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_comp", 32'(out_comp), 0);
        check("mid_rst_last", 32'(out_block_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        req = 3'b010;
        repeat (5) tick();
        check("post_rst_cb_ignored", 32'(grant), 0);
        force_en = 1'b1;
        tick();
        force_en = 1'b0;
        check("post_rst_err", 32'(err), 1);
        req = 3'b001;
        tick();
        check("post_rst_y_grant", 32'(grant), 1);
        check("post_rst_y_data", 32'(mem_data), 32'(11));
        repeat (63) tick();
        check("post_rst_y_64", 32'(grant), 1);
        req = 3'b000;
        tick();
        check("post_rst_y_65", 32'(grant), 0);
        check("post_rst_err_sticky", 32'(err), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
